// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC scan sequencer slice.
// Channel count, index width and result width are fixed here for the whole slice.
package adc_pkg;

  localparam int NCH    = 8;
  localparam int CHW    = 3;
  localparam int DATA_W = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CONVERT,
    S_OUTPUT
  } state_t;

  typedef struct packed {
    logic [CHW-1:0]    ch;
    logic [DATA_W-1:0] data;
    logic              last;
  } sample_t;

endpackage

// File: rtl/adc_next_ch.sv
// Priority search for the lowest set mask bit above (or, with incl, at or above) cur.
// found=0 means no such bit exists, i.e. cur is the last enabled channel.
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [CHW-1:0] cur,
  input  logic           incl,
  output logic [CHW-1:0] nxt,
  output logic           found
);

  // Descending scan so the lowest qualifying index is the final assignment.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        nxt   = CHW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Walks enabled mux channels on each sync: settle, convert, then hand the tagged
// sample downstream. Valid/ready: a sample transfers on any edge with smp_valid & smp_ready.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic              adc_clk,
  input  logic              rst_l,
  input  logic              sync,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              cont_mode,
  output logic [CHW-1:0]    mux_sel,
  output logic              mux_en,
  output logic              conv_req,
  input  logic              conv_ack,
  input  logic [DATA_W-1:0] conv_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [CHW-1:0]    smp_ch,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_last,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [NCH-1:0]   mask_q;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             restart_pend;
  sample_t          smp_q;

  logic [CHW-1:0]   cur_a;
  logic [CHW-1:0]   a_nxt;
  logic             a_found;
  logic [CHW-1:0]   b_nxt;
  logic             b_found;
  logic             sync_busy;
  logic             pend_now;
  logic             hs;

  // One cycle after a scan-start sync, search the latched mask from index 0 inclusive.
  assign cur_a     = start_q ? '0 : mux_sel;
  assign sync_busy = sync & busy;
  assign pend_now  = restart_pend | sync_busy;
  assign hs        = smp_valid & smp_ready;

  adc_next_ch u_next (
    .mask  (mask_q),
    .cur   (cur_a),
    .incl  (start_q),
    .nxt   (a_nxt),
    .found (a_found)
  );

  // First channel of the live mask, used when a restart re-latches ch_mask.
  adc_next_ch u_first (
    .mask  (ch_mask),
    .cur   ('0),
    .incl  (1'b1),
    .nxt   (b_nxt),
    .found (b_found)
  );

  assign smp_ch   = smp_q.ch;
  assign smp_data = smp_q.data;
  assign smp_last = smp_q.last;

  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      cnt          <= '0;
      start_q      <= 1'b0;
      restart_pend <= 1'b0;
      smp_q        <= '0;
      mux_sel      <= '0;
      mux_en       <= 1'b0;
      conv_req     <= 1'b0;
      smp_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sync_busy) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (sync_busy) restart_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          start_q <= 1'b0;
          if (start_q) begin
            mux_sel <= a_nxt;
            mux_en  <= 1'b1;
            busy    <= 1'b1;
            cnt     <= RELOAD;
            state   <= S_SETTLE;
          end else if (sync && (ch_mask != '0)) begin
            mask_q  <= ch_mask;
            start_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            conv_req <= 1'b1;
            state    <= S_CONVERT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CONVERT: begin
          if (conv_ack) begin
            smp_q     <= '{ch: mux_sel, data: conv_data, last: !a_found};
            conv_req  <= 1'b0;
            smp_valid <= 1'b1;
            state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (hs) begin
            smp_valid <= 1'b0;
            // A pending restart outranks both cont_mode and the end of the scan.
            if (pend_now || (smp_q.last && cont_mode)) begin
              restart_pend <= 1'b0;
              mask_q       <= ch_mask;
              if (b_found) begin
                mux_sel <= b_nxt;
                cnt     <= RELOAD;
                state   <= S_SETTLE;
              end else begin
                mux_sel <= '0;
                mux_en  <= 1'b0;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end
            end else if (!smp_q.last) begin
              mux_sel <= a_nxt;
              cnt     <= RELOAD;
              state   <= S_SETTLE;
            end else begin
              mux_sel      <= '0;
              mux_en       <= 1'b0;
              busy         <= 1'b0;
              restart_pend <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC responder and a
// sample monitor feeding an observed queue compared against hand-built expectations.
module tb_adc_scan_sequencer;

  logic        adc_clk = 1'b0;
  logic        rst_l;
  logic        sync;
  logic [7:0]  ch_mask;
  logic        cont_mode;
  logic [2:0]  mux_sel;
  logic        mux_en;
  logic        conv_req;
  logic        conv_ack;
  logic [12:0] conv_data;
  logic        smp_valid;
  logic        smp_ready;
  logic [2:0]  smp_ch;
  logic [12:0] smp_data;
  logic        smp_last;
  logic        busy;
  logic        overrun;
  logic        ovr_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int excl_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  always #5 adc_clk = ~adc_clk;

  adc_scan_sequencer #(.SETTLE_CYC(16)) dut (
    .adc_clk   (adc_clk),
    .rst_l     (rst_l),
    .sync      (sync),
    .ch_mask   (ch_mask),
    .cont_mode (cont_mode),
    .mux_sel   (mux_sel),
    .mux_en    (mux_en),
    .conv_req  (conv_req),
    .conv_ack  (conv_ack),
    .conv_data (conv_data),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_ch    (smp_ch),
    .smp_data  (smp_data),
    .smp_last  (smp_last),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  function automatic logic [12:0] model_data(input logic [2:0] ch);
    return 13'(ch) * 13'd300 + 13'd17;
  endfunction

  function automatic logic [16:0] exp_word(input int ch, input logic last);
    logic [2:0] c;
    c = 3'(ch);
    return {last, c, model_data(c)};
  endfunction

  // ADC model: acknowledge 5 cycles after conv_req rises, data derived from the channel.
  initial begin
    conv_ack  = 1'b0;
    conv_data = '0;
    forever begin
      @(negedge adc_clk);
      conv_ack = 1'b0;
      if (conv_req) begin
        repeat (4) @(negedge adc_clk);
        if (conv_req) begin
          conv_ack  = 1'b1;
          conv_data = model_data(mux_sel);
        end
      end
    end
  end

  // Sample monitor: records every transfer that will occur on the coming edge.
  initial begin
    forever begin
      @(negedge adc_clk);
      #1;
      if (smp_valid && conv_req) excl_err++;
      if (rst_l && smp_valid && smp_ready) obs_q.push_back({smp_last, smp_ch, smp_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge adc_clk);
    sync = 1'b0;
  endtask

  task automatic wait_count(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge adc_clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    @(negedge adc_clk);
    #1;
    n_cmp++;
    if ({mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_values: got %h expected 0",
               {mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun});
    end
    @(negedge adc_clk);
    rst_l = 1'b1;
    @(negedge adc_clk);
  endtask

  task automatic test_basic_scan();
    int lat;
    bit ok;
    obs_q.delete();
    exp_q.delete();
    ch_mask = 8'hA5;
    cont_mode = 1'b0;
    smp_ready = 1'b1;
    pulse_sync();
    lat = 0;
    while (!conv_req && lat < 100) begin
      @(negedge adc_clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 17) begin n_bad++; $display("FAIL first_req_latency: got %0d expected 17", lat); end
    n_cmp++;
    if ({mux_sel, mux_en, busy} !== 5'b000_1_1) begin
      n_bad++; $display("FAIL first_channel: got %b expected 00011", {mux_sel, mux_en, busy});
    end
    wait_count(4, 400, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout: got %0d samples expected 4", obs_q.size()); end
    @(negedge adc_clk);
    n_cmp++;
    if ({busy, smp_valid, mux_en} !== 3'b000) begin
      n_bad++; $display("FAIL basic_idle_after: got %b expected 000", {busy, smp_valid, mux_en});
    end
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(2, 1'b0));
    exp_q.push_back(exp_word(5, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL basic_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_mask();
    bit seen_busy;
    bit seen_req;
    obs_q.delete();
    seen_busy = 1'b0;
    seen_req = 1'b0;
    ch_mask = 8'h00;
    pulse_sync();
    repeat (30) begin
      @(negedge adc_clk);
      if (busy) seen_busy = 1'b1;
      if (conv_req) seen_req = 1'b1;
    end
    n_cmp++;
    if ({seen_busy, seen_req} !== 2'b00) begin
      n_bad++; $display("FAIL empty_mask_activity: got busy/req %b expected 00", {seen_busy, seen_req});
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL empty_mask_samples: got %0d expected 0", obs_q.size()); end
  endtask

  task automatic test_backpressure();
    int k;
    int lat;
    int stable_err;
    int req_err;
    bit ok;
    logic [17:0] held;
    obs_q.delete();
    exp_q.delete();
    ch_mask = 8'hA5;
    cont_mode = 1'b0;
    smp_ready = 1'b1;
    pulse_sync();
    k = 0;
    while (!(smp_valid && smp_ch == 3'd2) && k < 300) begin
      @(negedge adc_clk);
      k++;
    end
    n_cmp++;
    if (!(smp_valid && smp_ch == 3'd2)) begin n_bad++; $display("FAIL bp_reach_ch2: got ch %0d expected 2", smp_ch); end
    smp_ready = 1'b0;
    held = {smp_valid, smp_ch, smp_data, smp_last};
    stable_err = 0;
    req_err = 0;
    repeat (20) begin
      @(negedge adc_clk);
      if ({smp_valid, smp_ch, smp_data, smp_last} !== held) stable_err++;
      if (conv_req) req_err++;
    end
    n_cmp++;
    if (stable_err != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); end
    n_cmp++;
    if (req_err != 0) begin n_bad++; $display("FAIL bp_no_req: got %0d conv_req cycles expected 0", req_err); end
    smp_ready = 1'b1;
    lat = 0;
    while (!conv_req && lat < 100) begin
      @(negedge adc_clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 17) begin n_bad++; $display("FAIL bp_resume_latency: got %0d expected 17", lat); end
    n_cmp++;
    if (mux_sel !== 3'd5) begin n_bad++; $display("FAIL bp_next_channel: got %0d expected 5", mux_sel); end
    wait_count(4, 400, ok);
    @(negedge adc_clk);
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(2, 1'b0));
    exp_q.push_back(exp_word(5, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int k;
    bit ok;
    obs_q.delete();
    exp_q.delete();
    ch_mask = 8'hFF;
    cont_mode = 1'b0;
    smp_ready = 1'b1;
    pulse_sync();
    k = 0;
    while (!(conv_req && mux_sel == 3'd3) && k < 300) begin
      @(negedge adc_clk);
      k++;
    end
    n_cmp++;
    if (!(conv_req && mux_sel == 3'd3)) begin n_bad++; $display("FAIL ovr_reach_ch3: got ch %0d expected 3", mux_sel); end
    sync = 1'b1;
    ovr_clr = 1'b1;
    @(negedge adc_clk);
    sync = 1'b0;
    ovr_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
    wait_count(12, 800, ok);
    @(negedge adc_clk);
    n_cmp++;
    if ({overrun, busy} !== 2'b10) begin n_bad++; $display("FAIL ovr_sticky_idle: got %b expected 10", {overrun, busy}); end
    ovr_clr = 1'b1;
    @(negedge adc_clk);
    ovr_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    for (int c = 0; c < 4; c++) exp_q.push_back(exp_word(c, 1'b0));
    for (int c = 0; c < 8; c++) exp_q.push_back(exp_word(c, c == 7));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL ovr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ovr_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cont_mode();
    bit ok;
    obs_q.delete();
    exp_q.delete();
    ch_mask = 8'h81;
    cont_mode = 1'b1;
    smp_ready = 1'b1;
    pulse_sync();
    wait_count(5, 600, ok);
    ch_mask = 8'h02;
    wait_count(6, 200, ok);
    cont_mode = 1'b0;
    wait_count(7, 200, ok);
    @(negedge adc_clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_idle_after: got %b expected 0", busy); end
    repeat (40) @(negedge adc_clk);
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    exp_q.push_back(exp_word(1, 1'b1));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL cont_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL cont_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int k;
    bit ok;
    ch_mask = 8'hA5;
    cont_mode = 1'b0;
    smp_ready = 1'b1;
    pulse_sync();
    repeat (5) @(negedge adc_clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_settle_busy: got %b expected 1", busy); end
    rst_l = 1'b0;
    #1;
    n_cmp++;
    if ({mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun} !== 25'd0) begin
      n_bad++; $display("FAIL rst_in_settle: got %h expected 0",
                        {mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun});
    end
    @(negedge adc_clk);
    rst_l = 1'b1;
    @(negedge adc_clk);
    smp_ready = 1'b0;
    pulse_sync();
    k = 0;
    while (!smp_valid && k < 100) begin
      @(negedge adc_clk);
      k++;
    end
    n_cmp++;
    if ({smp_valid, smp_ch} !== 4'b1_000) begin
      n_bad++; $display("FAIL rst_reach_output: got %b expected 1000", {smp_valid, smp_ch});
    end
    rst_l = 1'b0;
    #1;
    n_cmp++;
    if ({mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun} !== 25'd0) begin
      n_bad++; $display("FAIL rst_in_output: got %h expected 0",
                        {mux_sel, mux_en, conv_req, smp_valid, smp_ch, smp_data, smp_last, busy, overrun});
    end
    @(negedge adc_clk);
    rst_l = 1'b1;
    smp_ready = 1'b1;
    @(negedge adc_clk);
    obs_q.delete();
    exp_q.delete();
    pulse_sync();
    wait_count(4, 400, ok);
    @(negedge adc_clk);
    exp_q.push_back(exp_word(0, 1'b0));
    exp_q.push_back(exp_word(2, 1'b0));
    exp_q.push_back(exp_word(5, 1'b0));
    exp_q.push_back(exp_word(7, 1'b1));
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rst_rescan_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rst_rescan_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_exclusion();
    n_cmp++;
    if (excl_err != 0) begin
      n_bad++; $display("FAIL valid_req_exclusive: got %0d overlap cycles expected 0", excl_err);
    end
  endtask

  initial begin
    rst_l     = 1'b0;
    sync      = 1'b0;
    ch_mask   = '0;
    cont_mode = 1'b0;
    smp_ready = 1'b1;
    ovr_clr   = 1'b0;
    test_reset();
    test_basic_scan();
    test_empty_mask();
    test_backpressure();
    test_overrun();
    test_cont_mode();
    test_reset_mid_scan();
    test_exclusion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
